lc3b_mar_mdr_ctrl: RTL and testbench
====================================

Name: lc3b_mar_mdr_ctrl

Overview:
- Sits directly downstream of the MARMUX bus gate: it captures the shared 16-bit bus into MAR and runs the memory access for the LC-3b datapath.
- Owns MAR and MDR, byte-lane write enables, and the multi-cycle memory handshake.
- Returns the ready signal R to the microsequencer.
- MDR output feeds the GateMDR bus driver; byte select and sign-extension are done there.

Parameters:
- ADDR_W, 16, width of MAR and the memory address.
- DATA_W, 16, width of the bus, MDR and memory data; fixed at 16 because byte lanes assume 2 bytes.
- TIMEOUT_CYCLES, 15, max cycles spent in ACCESS before abort; used only with LC3B_MEM_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- bus  in  16  shared datapath bus
- ld_mar  in  1  load MAR from bus
- ld_mdr  in  1  load MDR (from bus when mio_en=0, from memory when mio_en=1)
- mio_en  in  1  memory access request, held by microsequencer until r seen
- r_w  in  1  0=read, 1=write
- data_size  in  1  0=byte, 1=word
- mar  out  16  MAR contents / memory address
- mdr  out  16  MDR contents
- mem_en  out  1  memory access strobe
- mem_we  out  2  byte write enables {hi, lo}
- mem_wdata  out  16  equals mdr
- mem_rdata  in  16  memory read data
- mem_ready  in  1  memory completes access this cycle
- r  out  1  one-cycle completion pulse to microsequencer
- unaligned  out  1  one-cycle pulse with r: word access at odd address
- timeout  out  1  one-cycle pulse with r: watchdog abort (0 without macro)

Behaviour:
- Reset (async, immediate): state=IDLE; mar=0, mdr=0, mem_en=0, mem_we=0, r=0, unaligned=0, timeout=0.
- Reset mid-access aborts the transaction: mem_en drops in the same cycle as reset asserts.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - mio_en=1 latches r_w and data_size, then goes to ACCESS.
  - Exception: data_size=1 with mar[0]=1 goes to DONE with unaligned set, and no memory access occurs.
- ACCESS:
  - mem_en=1 (registered, so asserted the cycle after the request).
  - mem_we: write word gives 2'b11; write byte gives 2'b10 if mar[0]=1, else 2'b01; read gives 2'b00.
  - mem_ready=1 at an edge: on a read with ld_mdr=1, mdr<=mem_rdata; goes to DONE.
  - mem_ready=1 on the first ACCESS cycle is legal; minimum latency from mio_en to r is 2 cycles.
- DONE: r=1, mem_en=0, mem_we=0. Always returns to IDLE; mio_en is ignored in DONE, so a held request cannot retrigger.
- ld_mar: honoured only in IDLE; ignored in ACCESS and DONE so the address stays stable. ld_mar together with mio_en in IDLE: the access uses the old mar, and mar updates at the same edge.
- ld_mdr with mio_en=0 in any state:
  - word: mdr<=bus.
  - byte: mdr<={bus[7:0], bus[7:0]} (replicated for either lane).
- ld_mdr=0 during a read: data is discarded and mdr is unchanged.
- mem_ready outside ACCESS is ignored.
- unaligned and timeout are never asserted together.

Optional Feature:
- LC3B_MEM_TIMEOUT_EN defined:
  - A counter clears on entry to ACCESS and increments each ACCESS cycle without mem_ready.
  - When it reaches TIMEOUT_CYCLES, the block goes to DONE with timeout=1; mdr is unchanged.
  - mem_ready on the same cycle as the limit wins: normal completion, no timeout.
- Undefined: ACCESS waits indefinitely; timeout is tied to 0; no counter logic is present.

Decomposition:
- Package lc3b_mem_pkg holds:
  - state encoding (IDLE, ACCESS, DONE);
  - R_W_READ/R_W_WRITE, SIZE_BYTE/SIZE_WORD constants;
  - WE_NONE/WE_LO/WE_HI/WE_BOTH constants.
- One sub-module, lc3b_mem_watchdog: cycle counter with clear, enable and expire; instantiated only under LC3B_MEM_TIMEOUT_EN.

Test Plan:
- Reset mid-access: assert reset during ACCESS -> mem_en=0 immediately; after release mar=0, mdr=0, state IDLE, r=0.
- Word read: bus=16'h3000 with ld_mar, then mio_en=1, r_w=0, size=1, ld_mdr=1; mem_ready after 3 cycles with rdata=16'hBEEF -> mem_en high for 3 cycles, mdr=16'hBEEF, r pulses once, the next cycle is IDLE.
- Byte write odd: mar=16'h3001, ld_mdr with bus=16'h12AB and size=0 -> mdr=16'hABAB; then mio_en, r_w=1 -> mem_we=2'b10, mem_wdata=16'hABAB, r after mem_ready.
- Unaligned: mar=16'h3003, word read request -> mem_en never asserted; r and unaligned pulse together 1 cycle after the request; mdr unchanged.
- Held request and ld_mar in ACCESS: mio_en held high through DONE -> exactly one r pulse; ld_mar with bus=16'h4000 during ACCESS -> mar stays 16'h3000.
- With LC3B_MEM_TIMEOUT_EN and TIMEOUT_CYCLES=4, mem_ready never asserted -> r and timeout pulse after 4 ACCESS cycles, mdr unchanged. Repeat with mem_ready on cycle 4 -> normal completion, timeout=0.

Source files
------------

// File: rtl/lc3b_mem_pkg.sv
// Shared encodings for the LC-3b MAR/MDR memory controller: FSM states,
// access type/size codes, byte-lane write-enable patterns.
package lc3b_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } mem_state_e;

  localparam logic R_W_READ  = 1'b0;
  localparam logic R_W_WRITE = 1'b1;
  localparam logic SIZE_BYTE = 1'b0;
  localparam logic SIZE_WORD = 1'b1;

  localparam logic [1:0] WE_NONE = 2'b00;
  localparam logic [1:0] WE_LO   = 2'b01;
  localparam logic [1:0] WE_HI   = 2'b10;
  localparam logic [1:0] WE_BOTH = 2'b11;

  // Byte-lane enables {hi, lo}; a byte store picks its lane from address bit 0.
  function automatic logic [1:0] lane_we(input logic rw, input logic size, input logic a0);
    logic [1:0] we;
    if (rw == R_W_READ) begin
      we = WE_NONE;
    end else if (size == SIZE_WORD) begin
      we = WE_BOTH;
    end else if (a0) begin
      we = WE_HI;
    end else begin
      we = WE_LO;
    end
    return we;
  endfunction

endpackage

// File: rtl/lc3b_mem_watchdog.sv
// ACCESS-phase cycle counter for the memory controller; expire is asserted
// combinationally on the enabled cycle that would bring the count to LIMIT.
module lc3b_mem_watchdog #(
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] count_r;

  // Count stalled ACCESS cycles; cleared on entry to a new access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r <= '0;
    end else if (clear) begin
      count_r <= '0;
    end else if (enable) begin
      count_r <= count_r + CW'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign expire = enable && (count_r == CW'(LIMIT - 1));

endmodule

// File: rtl/lc3b_mar_mdr_ctrl.sv
// LC-3b MAR/MDR owner and memory handshake FSM (IDLE -> ACCESS -> DONE).
// Optional access watchdog enabled with `define LC3B_MEM_TIMEOUT_EN.
module lc3b_mar_mdr_ctrl
  import lc3b_mem_pkg::*;
#(
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 16,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] bus,
  input  logic              ld_mar,
  input  logic              ld_mdr,
  input  logic              mio_en,
  input  logic              r_w,
  input  logic              data_size,
  output logic [ADDR_W-1:0] mar,
  output logic [DATA_W-1:0] mdr,
  output logic              mem_en,
  output logic [1:0]        mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              r,
  output logic              unaligned,
  output logic              timeout
);

  mem_state_e        state_r, next_state_s;
  logic              rw_r;
  logic [ADDR_W-1:0] mar_r;
  logic [DATA_W-1:0] mdr_r;
  logic              mem_en_r;
  logic [1:0]        mem_we_r, we_next_s;
  logic              r_r, unaligned_r, timeout_r;
  logic              start_s, unaligned_s, timeout_s, rd_cap_s;
  logic              wd_expire_s;

`ifdef LC3B_MEM_TIMEOUT_EN
  logic wd_enable_s;

  assign wd_enable_s = (state_r == ST_ACCESS) && !mem_ready;

  lc3b_mem_watchdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (start_s),
    .enable (wd_enable_s),
    .expire (wd_expire_s)
  );
`else
  logic [31:0] unused_timeout_cycles;

  assign unused_timeout_cycles = 32'(TIMEOUT_CYCLES);
  assign wd_expire_s           = 1'b0;
`endif

  // Next-state and per-transition event decode.
  always_comb begin
    next_state_s = state_r;
    start_s      = 1'b0;
    unaligned_s  = 1'b0;
    timeout_s    = 1'b0;
    rd_cap_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (mio_en) begin
          start_s = 1'b1;
          if ((data_size == SIZE_WORD) && mar_r[0]) begin
            next_state_s = ST_DONE;
            unaligned_s  = 1'b1;
          end else begin
            next_state_s = ST_ACCESS;
          end
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (mem_ready) begin
          next_state_s = ST_DONE;
          rd_cap_s     = (rw_r == R_W_READ) && ld_mdr;
        end else if (wd_expire_s) begin
          next_state_s = ST_DONE;
          timeout_s    = 1'b1;
        end else begin
          next_state_s = ST_ACCESS;
        end
      end
      ST_DONE: begin
        next_state_s = ST_IDLE;
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // Lane enables are fixed at request time and held for the whole access.
  always_comb begin
    if (state_r == ST_IDLE) begin
      we_next_s = lane_we(r_w, data_size, mar_r[0]);
    end else begin
      we_next_s = mem_we_r;
    end
  end

  // FSM state, latched direction and registered handshake outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      rw_r        <= R_W_READ;
      mem_en_r    <= 1'b0;
      mem_we_r    <= WE_NONE;
      r_r         <= 1'b0;
      unaligned_r <= 1'b0;
      timeout_r   <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      rw_r        <= start_s ? r_w : rw_r;
      mem_en_r    <= (next_state_s == ST_ACCESS);
      mem_we_r    <= (next_state_s == ST_ACCESS) ? we_next_s : WE_NONE;
      r_r         <= (next_state_s == ST_DONE);
      unaligned_r <= unaligned_s;
      timeout_r   <= timeout_s;
    end
  end

  // MAR only moves in IDLE so the address is stable for the whole access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mar_r <= '0;
    end else if (ld_mar && (state_r == ST_IDLE)) begin
      mar_r <= bus[ADDR_W-1:0];
    end else begin
      mar_r <= mar_r;
    end
  end

  // MDR: memory capture on read completion, else bus load (byte replicated).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mdr_r <= '0;
    end else if (rd_cap_s) begin
      mdr_r <= mem_rdata;
    end else if (ld_mdr && !mio_en) begin
      if (data_size == SIZE_WORD) begin
        mdr_r <= bus;
      end else begin
        mdr_r <= {bus[7:0], bus[7:0]};
      end
    end else begin
      mdr_r <= mdr_r;
    end
  end

  assign mar       = mar_r;
  assign mdr       = mdr_r;
  assign mem_en    = mem_en_r;
  assign mem_we    = mem_we_r;
  assign mem_wdata = mdr_r;
  assign r         = r_r;
  assign unaligned = unaligned_r;
  assign timeout   = timeout_r;

endmodule

// File: tb/tb_lc3b_mar_mdr_ctrl.sv
// Scoreboard bench for lc3b_mar_mdr_ctrl; timeout cases run when
// LC3B_MEM_TIMEOUT_EN is defined (DUT built with TIMEOUT_CYCLES=4).
module tb_lc3b_mar_mdr_ctrl;

  typedef struct packed {
    logic [15:0] mdr;
    logic        un;
    logic        to;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] bus;
  logic        ld_mar, ld_mdr, mio_en, r_w, data_size;
  logic [15:0] mar, mdr, mem_wdata, mem_rdata;
  logic        mem_en, mem_ready, r, unaligned, timeout;
  logic [1:0]  mem_we;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   r_count = 0;
  int   en_cycles = 0;

  lc3b_mar_mdr_ctrl #(
    .ADDR_W         (16),
    .DATA_W         (16),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .ld_mar    (ld_mar),
    .ld_mdr    (ld_mdr),
    .mio_en    (mio_en),
    .r_w       (r_w),
    .data_size (data_size),
    .mar       (mar),
    .mdr       (mdr),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .r         (r),
    .unaligned (unaligned),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_mar(input logic [15:0] v);
    bus = v; ld_mar = 1'b1;
    tick();
    ld_mar = 1'b0;
  endtask

  task automatic load_mdr(input logic [15:0] v, input logic sz);
    bus = v; data_size = sz; ld_mdr = 1'b1;
    tick();
    ld_mdr = 1'b0;
  endtask

  task automatic push(input logic [15:0] m, input logic u, input logic t);
    exp_t e;
    e.mdr = m; e.un = u; e.to = t;
    exp_q.push_back(e);
  endtask

  // Monitor: every completion pulse is checked against the scoreboard head.
  always @(negedge clk) begin
    if (!reset) begin
      if (mem_en === 1'b1) en_cycles++;
      if (r === 1'b1) begin
        exp_t e;
        r_count++;
        if (exp_q.size() == 0) begin
          chk("unexpected_r", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("r_mdr", {16'd0, mdr}, {16'd0, e.mdr});
          chk("r_unaligned", {31'd0, unaligned}, {31'd0, e.un});
          chk("r_timeout", {31'd0, timeout}, {31'd0, e.to});
        end
      end
    end
  end

  initial begin
    reset = 1'b1; bus = 16'h0000; ld_mar = 1'b0; ld_mdr = 1'b0; mio_en = 1'b0;
    r_w = 1'b0; data_size = 1'b0; mem_rdata = 16'h0000; mem_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_mar", {16'd0, mar}, 32'h0);
    chk("rst_mdr", {16'd0, mdr}, 32'h0);
    chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
    chk("rst_mem_we", {30'd0, mem_we}, 32'd0);
    chk("rst_r", {29'd0, r, unaligned, timeout}, 32'd0);

    // Word read, memory answers on the third ACCESS cycle.
    load_mar(16'h3000);
    chk("rd_mar", {16'd0, mar}, 32'h3000);
    en_cycles = 0; r_count = 0;
    push(16'hBEEF, 1'b0, 1'b0);
    mio_en = 1'b1; r_w = 1'b0; data_size = 1'b1; ld_mdr = 1'b1;
    tick();
    chk("rd_mem_en", {31'd0, mem_en}, 32'd1);
    chk("rd_mem_we", {30'd0, mem_we}, 32'd0);
    tick(); tick();
    mem_ready = 1'b1; mem_rdata = 16'hBEEF;
    tick();
    mem_ready = 1'b0; mio_en = 1'b0; ld_mdr = 1'b0;
    chk("rd_done_mem_en", {31'd0, mem_en}, 32'd0);
    tick();
    chk("rd_idle_r", {31'd0, r}, 32'd0);
    chk("rd_en_cycles", en_cycles, 3);
    chk("rd_r_count", r_count, 1);

    // Byte write at odd address goes to the high lane.
    load_mar(16'h3001);
    load_mdr(16'h12AB, 1'b0);
    chk("bw_mdr_repl", {16'd0, mdr}, 32'hABAB);
    en_cycles = 0;
    push(16'hABAB, 1'b0, 1'b0);
    mio_en = 1'b1; r_w = 1'b1; data_size = 1'b0;
    tick();
    chk("bwo_mem_we", {30'd0, mem_we}, 32'h2);
    chk("bwo_wdata", {16'd0, mem_wdata}, 32'hABAB);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0; mio_en = 1'b0;
    tick();
    chk("bwo_en_cycles", en_cycles, 1);

    // Byte write at even address goes to the low lane.
    load_mar(16'h3000);
    load_mdr(16'h00C3, 1'b0);
    push(16'hC3C3, 1'b0, 1'b0);
    mio_en = 1'b1; r_w = 1'b1; data_size = 1'b0;
    tick();
    chk("bwe_mem_we", {30'd0, mem_we}, 32'h1);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0; mio_en = 1'b0;
    tick();

    // Unaligned word read: no memory strobe, immediate completion.
    load_mar(16'h3003);
    en_cycles = 0; r_count = 0;
    push(16'hC3C3, 1'b1, 1'b0);
    mio_en = 1'b1; r_w = 1'b0; data_size = 1'b1; ld_mdr = 1'b1;
    mem_ready = 1'b1; mem_rdata = 16'h5555;
    tick();
    chk("ua_r", {30'd0, r, unaligned}, 32'h3);
    mio_en = 1'b0; ld_mdr = 1'b0; mem_ready = 1'b0;
    tick(); tick();
    chk("ua_en_cycles", en_cycles, 0);
    chk("ua_r_count", r_count, 1);

    // Held request through DONE and ld_mar attempts during the access.
    load_mar(16'h3000);
    r_count = 0;
    push(16'hC3C3, 1'b0, 1'b0);
    mio_en = 1'b1; r_w = 1'b0; data_size = 1'b1; ld_mdr = 1'b0;
    tick();
    bus = 16'h4000; ld_mar = 1'b1;
    tick();
    chk("hold_mar_access", {16'd0, mar}, 32'h3000);
    mem_ready = 1'b1; mem_rdata = 16'h1111;
    tick();
    mem_ready = 1'b0;
    tick();
    mio_en = 1'b0; ld_mar = 1'b0;
    chk("hold_mar_done", {16'd0, mar}, 32'h3000);
    tick(); tick(); tick();
    chk("hold_r_count", r_count, 1);
    chk("hold_mem_en", {31'd0, mem_en}, 32'd0);

    // Reset during ACCESS drops the strobe immediately.
    load_mar(16'h3000);
    mio_en = 1'b1; r_w = 1'b0; data_size = 1'b1;
    tick();
    chk("mid_mem_en_before", {31'd0, mem_en}, 32'd1);
    #2 reset = 1'b1;
    #1 chk("mid_mem_en_async", {31'd0, mem_en}, 32'd0);
    tick();
    reset = 1'b0; mio_en = 1'b0;
    tick();
    chk("mid_mar", {16'd0, mar}, 32'h0);
    chk("mid_mdr", {16'd0, mdr}, 32'h0);
    chk("mid_r_en", {30'd0, r, mem_en}, 32'd0);

`ifdef LC3B_MEM_TIMEOUT_EN
    // Memory never answers: watchdog aborts after four ACCESS cycles.
    load_mar(16'h3000);
    load_mdr(16'h7777, 1'b1);
    en_cycles = 0;
    push(16'h7777, 1'b0, 1'b1);
    mio_en = 1'b1; r_w = 1'b0; data_size = 1'b1; ld_mdr = 1'b1;
    tick(); tick(); tick(); tick(); tick();
    mio_en = 1'b0; ld_mdr = 1'b0;
    tick();
    chk("to_en_cycles", en_cycles, 4);

    // Ready on the limit cycle wins over the watchdog.
    en_cycles = 0;
    push(16'hCAFE, 1'b0, 1'b0);
    mio_en = 1'b1; ld_mdr = 1'b1;
    tick(); tick(); tick(); tick();
    mem_ready = 1'b1; mem_rdata = 16'hCAFE;
    tick();
    mem_ready = 1'b0; mio_en = 1'b0; ld_mdr = 1'b0;
    tick();
    chk("tor_en_cycles", en_cycles, 4);
`endif

    tick(); tick();
    chk("sb_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
